data_mem_responder: RTL

Multi-cycle data-memory responder answering the CPU's load/store requests over a valid/ready request channel and a valid/ready response channel. It is the memory side of the core's data-access interface. It replaces the zero-latency RAM path when wait states are needed. It provides byte/halfword/word access, little-endian lane placement, load sign/zero extension, misalignment and range checking, and a configurable number of wait states.

---
 rtl/data_mem_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Wait-state data memory behind valid/ready request and response channels.
// Byte/half/word little-endian access, load extension, alignment and range errors.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int         AW      = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                       r_state, w_next;
   logic [3:0]                   r_cnt;
   logic                         r_we, r_uns, r_err;
   logic [1:0]                   r_size;
   logic [31:0]                  r_addr, r_wdata, r_rdata;
   logic [DEPTH_WORDS-1:0][31:0] r_mem;

   logic          w_accept, w_exec, w_err;
   logic          w_we, w_uns;
   logic [1:0]    w_size, w_lane;
   logic [31:0]   w_addr, w_wdata, w_word, w_load, w_wd, w_new;
   logic [AW-1:0] w_idx;
   logic [15:0]   w_sh;
   logic [3:0]    w_be;

   assign w_accept = (r_state == S_IDLE) && req_valid;

   // With no wait states the access runs on the acceptance edge, so it reads the ports directly.
   always_comb begin
      if (r_state == S_IDLE) begin
         w_we = req_we; w_size = req_size; w_uns = req_unsigned;
         w_addr = req_addr; w_wdata = req_wdata;
      end else begin
         w_we = r_we; w_size = r_size; w_uns = r_uns;
         w_addr = r_addr; w_wdata = r_wdata;
      end
   end

   assign w_err  = (w_size == 2'b11)
                || (w_size == 2'b01 && w_addr[0])
                || (w_size == 2'b10 && w_addr[1:0] != 2'b00)
                || ((w_addr >> (AW + 2)) != 32'd0);
   assign w_idx  = w_addr[AW+1:2];
   assign w_lane = w_addr[1:0];
   assign w_word = r_mem[w_idx];
   assign w_sh   = 16'(w_word >> {w_lane, 3'b000});

   always_comb begin
      w_load = w_word;
      case (w_size)
         2'b00:   w_load = w_uns ? {24'd0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
         2'b01:   w_load = w_uns ? {16'd0, w_sh} : {{16{w_sh[15]}}, w_sh};
         default: w_load = w_word;
      endcase
   end

   always_comb begin
      w_wd = w_wdata;
      w_be = 4'hF;
      case (w_size)
         2'b00:   begin w_wd = {4{w_wdata[7:0]}};  w_be = 4'b0001 << w_lane; end
         2'b01:   begin w_wd = {2{w_wdata[15:0]}}; w_be = 4'b0011 << {w_lane[1], 1'b0}; end
         default: begin w_wd = w_wdata;            w_be = 4'hF; end
      endcase
      for (int b = 0; b < 4; b++)
         w_new[8*b +: 8] = w_be[b] ? w_wd[8*b +: 8] : w_word[8*b +: 8];
   end

   always_comb begin
      w_next = r_state;
      w_exec = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) begin
            if (WAIT_CYCLES == 0) begin w_next = S_RESP; w_exec = 1'b1; end
            else w_next = S_WAIT;
         end
         S_WAIT: if (r_cnt <= 4'd1) begin w_next = S_RESP; w_exec = 1'b1; end
         S_RESP: if (resp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_size  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_mem   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we <= req_we; r_size <= req_size; r_uns <= req_unsigned;
            r_addr <= req_addr; r_wdata <= req_wdata;
            r_cnt <= LP_WAIT;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_exec) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
            if (!w_err && w_we) r_mem[w_idx] <= w_new;
         end
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;
endmodule
